cpu_run_ctrl: RTL

- Run/step/breakpoint sequencer for the single-cycle MIPS core.
- Produces the core's execution enable (`cpu_en`), which gates the PC, register-file and data-memory write strobes.
- Takes button-level run/step/pause commands from the board, a PC breakpoint compare, and the core's syscall-exit halt.
- Counts retired instructions for the seven-segment/debug display.

---
 rtl/cpu_run_ctrl_if.sv | 42 ++++
 rtl/cpu_run_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: the bundle of signals between the board, the core and the
// run/step/breakpoint sequencer.
//   master : board/core side. It drives the buttons, pc, breakpoint setup and
//            cpu_halt, and receives cpu_en, state and the status flags.
//   slave  : sequencer side (cpu_run_ctrl).
// Signals:
//   run_btn/step_btn/pause_btn : button levels; commands fire on rising edges
//   pc, bp_addr, bp_en         : current PC and breakpoint compare setup
//   cpu_halt                   : syscall-exit halt from the core (combinational)
//   cpu_en                     : execute enable to the core (combinational)
//   state                      : PAUSE=0, RUN=1, STEP=2, DONE=3
//   step_done                  : one-cycle pulse after a step retires
//   bp_hit, wdog_to            : sticky causes of the last pause
//   retired                    : saturating count of executed cycles
interface cpu_run_ctrl_if #(
  parameter int BP_W  = 32,
  parameter int CNT_W = 16
);
  logic             run_btn;
  logic             step_btn;
  logic             pause_btn;
  logic [BP_W-1:0]  pc;
  logic [BP_W-1:0]  bp_addr;
  logic             bp_en;
  logic             cpu_halt;
  logic             cpu_en;
  logic [1:0]       state;
  logic             step_done;
  logic             bp_hit;
  logic             wdog_to;
  logic [CNT_W-1:0] retired;

  modport master (
    output run_btn, step_btn, pause_btn, pc, bp_addr, bp_en, cpu_halt,
    input  cpu_en, state, step_done, bp_hit, wdog_to, retired
  );

  modport slave (
    input  run_btn, step_btn, pause_btn, pc, bp_addr, bp_en, cpu_halt,
    output cpu_en, state, step_done, bp_hit, wdog_to, retired
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step/breakpoint sequencer for the single-cycle MIPS core.
// It produces cpu_en, which gates the PC, register-file and data-memory write
// strobes. It takes edge-detected run/step/pause buttons, a PC breakpoint
// compare and the core's syscall-exit halt, and it counts retired instructions.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   ctrl  : cpu_run_ctrl_if.slave (buttons, pc/breakpoint, halt, cpu_en, state,
//           step_done, bp_hit, wdog_to, retired)
// Build option:
//   WATCHDOG_EN : when defined, adds a RUN-cycle watchdog (parameter WDOG_LIMIT)
//                 that pauses the core and sets wdog_to. When not defined,
//                 wdog_to is tied to 0 and RUN has no time limit.
module cpu_run_ctrl #(
  parameter int BP_W  = 32,
  parameter int CNT_W = 16
`ifdef WATCHDOG_EN
  , parameter logic [15:0] WDOG_LIMIT = 16'd50000
`endif
) (
  input logic          clk,
  input logic          reset,
  cpu_run_ctrl_if.slave ctrl
);

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             run_btn_q, step_btn_q, pause_btn_q;
  logic             skip_q, skip_d;
  logic             step_done_q, step_done_d;
  logic             bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic             cmd_run, cmd_step, cmd_pause;
  logic [BP_W-1:0]  pc_diff;
  logic             bp_match;
  logic             wdog_stop;
  logic             cpu_en;

  assign cmd_run   = ctrl.run_btn   & ~run_btn_q;
  assign cmd_step  = ctrl.step_btn  & ~step_btn_q;
  assign cmd_pause = ctrl.pause_btn & ~pause_btn_q;

  // skip masks the compare for the first instruction after a resume, so
  // run/step from a breakpoint PC does not immediately re-hit it.
  assign pc_diff  = ctrl.pc ^ ctrl.bp_addr;
  assign bp_match = ctrl.bp_en & ~(|pc_diff) & ~skip_q;

`ifdef WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_LIMIT - 16'd1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_to_q, wdog_to_d;

  // Watchdog expiry only takes effect when no higher-priority cause
  // (halt, pause, breakpoint) is present in the same cycle.
  assign wdog_stop = (state_q == ST_RUN) && (wdog_cnt_q == WDOG_LAST)
                     && !ctrl.cpu_halt && !cmd_pause && !bp_match;

  always_comb begin
    wdog_cnt_d = '0;
    if (state_q == ST_RUN) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt_q <= '0;
      wdog_to_q  <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_to_q  <= wdog_to_d;
    end
  end

  assign ctrl.wdog_to = wdog_to_q;
`else
  assign wdog_stop    = 1'b0;
  assign ctrl.wdog_to = 1'b0;
`endif

  // The instruction at the breakpoint PC (or in the watchdog-expiry cycle) is
  // held off; a pause command alone still lets the in-flight instruction run.
  assign cpu_en = (((state_q == ST_RUN) & ~bp_match & ~wdog_stop)
                   | (state_q == ST_STEP)) & ~ctrl.cpu_halt;

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    step_done_d = 1'b0;
    bp_hit_d    = bp_hit_q;
`ifdef WATCHDOG_EN
    wdog_to_d   = wdog_to_q;
`endif
    retired_d   = retired_q;

    if (cpu_en) begin
      skip_d = 1'b0;
      if (retired_q != {CNT_W{1'b1}}) begin
        retired_d = retired_q + 1'b1;
      end
    end

    case (state_q)
      ST_PAUSE: begin
        // pause outranks step and run even though pause itself does nothing here
        if (!cmd_pause) begin
          if (cmd_step) begin
            state_d = ST_STEP;
            skip_d  = 1'b1;
          end else if (cmd_run) begin
            state_d  = ST_RUN;
            skip_d   = 1'b1;
            bp_hit_d = 1'b0;
`ifdef WATCHDOG_EN
            wdog_to_d = 1'b0;
`endif
          end
        end
      end
      ST_RUN: begin
        if (ctrl.cpu_halt) begin
          state_d = ST_DONE;
        end else if (cmd_pause) begin
          state_d = ST_PAUSE;
        end else if (bp_match) begin
          state_d  = ST_PAUSE;
          bp_hit_d = 1'b1;
        end
`ifdef WATCHDOG_EN
        else if (wdog_stop) begin
          state_d   = ST_PAUSE;
          wdog_to_d = 1'b1;
        end
`endif
      end
      ST_STEP: begin
        if (ctrl.cpu_halt) begin
          state_d = ST_DONE;
        end else begin
          state_d     = ST_PAUSE;
          step_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_PAUSE;
      end
    endcase
  end

  // Button history resets to 1 so a button held through reset is not seen
  // as a fresh press when reset releases.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_PAUSE;
      run_btn_q   <= 1'b1;
      step_btn_q  <= 1'b1;
      pause_btn_q <= 1'b1;
      skip_q      <= 1'b0;
      step_done_q <= 1'b0;
      bp_hit_q    <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      run_btn_q   <= ctrl.run_btn;
      step_btn_q  <= ctrl.step_btn;
      pause_btn_q <= ctrl.pause_btn;
      skip_q      <= skip_d;
      step_done_q <= step_done_d;
      bp_hit_q    <= bp_hit_d;
      retired_q   <= retired_d;
    end
  end

  assign ctrl.cpu_en    = cpu_en;
  assign ctrl.state     = state_q;
  assign ctrl.step_done = step_done_q;
  assign ctrl.bp_hit    = bp_hit_q;
  assign ctrl.retired   = retired_q;

endmodule
